// File: rtl/nxd_timer_pkg.sv
// Shared definitions for the non-existent-device IO timer: state encodings,
// the default timeout and the VMA physical IO address width.
package nxd_timer_pkg;

    localparam int NXD_TIMEOUT_DEFAULT = 64;
    localparam int VMA_ADDR_WIDTH      = 22;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2,
        ST_TMO  = 2'd3
    } nxd_state_t;

    // A timeout of 1 still needs a one-bit counter.
    function automatic int count_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/nxd_timer.sv
// IO cycle watchdog: stalls the microsequencer until the addressed device acks,
// and flags a non-existent device if no ack arrives within nxdTIMEOUT enabled cycles.
module nxd_timer
    import nxd_timer_pkg::*;
#(
    parameter int nxdTIMEOUT = NXD_TIMEOUT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clken,
    input  logic                      iolatch,
    input  logic [VMA_ADDR_WIDTH-1:0] ioADDR,
    input  logic                      ioACK,
    input  logic                      clrNXD,
    output logic                      ioWAIT,
    output logic                      ioDONE,
    output logic                      nxdINTR,
    output logic                      nxdERR,
    output logic [VMA_ADDR_WIDTH-1:0] nxdADDR
);

    localparam int            CW         = count_width(nxdTIMEOUT);
    localparam logic [CW-1:0] COUNT_LOAD = CW'(nxdTIMEOUT - 1);

    nxd_state_t                state;
    nxd_state_t                state_next;
    logic [CW-1:0]             count;
    logic                      last_iolatch;
    logic                      primed;
    logic [VMA_ADDR_WIDTH-1:0] cur_addr;
    logic                      start;
    logic                      tmo_entry;

    // primed stays low after reset until iolatch has been seen low, so a latch
    // already high when reset releases is never taken as a new IO cycle.
    assign start     = iolatch & ~last_iolatch & primed;
    assign tmo_entry = (state == ST_WAIT) & ~ioACK & (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else if (clken) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (start) state_next = ST_WAIT;
            ST_WAIT: begin
                if (ioACK) begin
                    state_next = ST_DONE;
                end else if (count == '0) begin
                    state_next = ST_TMO;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            ST_TMO:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ioWAIT  = (state == ST_WAIT);
        ioDONE  = (state == ST_DONE);
        nxdINTR = (state == ST_TMO);
    end

    // Datapath; a timeout on the same cycle as clrNXD leaves the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_iolatch <= 1'b0;
            primed       <= 1'b0;
            count        <= '0;
            cur_addr     <= '0;
            nxdERR       <= 1'b0;
            nxdADDR      <= '0;
        end else if (clken) begin
            last_iolatch <= iolatch;
            primed       <= primed | ~iolatch;
            if ((state == ST_IDLE) && start) begin
                count    <= COUNT_LOAD;
                cur_addr <= ioADDR;
            end else if ((state == ST_WAIT) && !ioACK && (count != '0)) begin
                count <= count - CW'(1);
            end
            if (tmo_entry) begin
                nxdERR  <= 1'b1;
                nxdADDR <= cur_addr;
            end else if (clrNXD) begin
                nxdERR <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nxd_timer.sv
// Directed self-checking bench for nxd_timer with the default 64-cycle timeout.
module tb_nxd_timer;

    logic        clk;
    logic        rst;
    logic        clken;
    logic        iolatch;
    logic [21:0] ioADDR;
    logic        ioACK;
    logic        clrNXD;
    logic        ioWAIT;
    logic        ioDONE;
    logic        nxdINTR;
    logic        nxdERR;
    logic [21:0] nxdADDR;

    int tests_run = 0;
    int tests_failed = 0;
    int bad;

    nxd_timer #(.nxdTIMEOUT(64)) dut (
        .clk(clk),
        .rst(rst),
        .clken(clken),
        .iolatch(iolatch),
        .ioADDR(ioADDR),
        .ioACK(ioACK),
        .clrNXD(clrNXD),
        .ioWAIT(ioWAIT),
        .ioDONE(ioDONE),
        .nxdINTR(nxdINTR),
        .nxdERR(nxdERR),
        .nxdADDR(nxdADDR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic w, input logic d, input logic i,
                                 input logic e, input logic [21:0] a);
        check({tag, ".ioWAIT"}, 32'(ioWAIT), 32'(w));
        check({tag, ".ioDONE"}, 32'(ioDONE), 32'(d));
        check({tag, ".nxdINTR"}, 32'(nxdINTR), 32'(i));
        check({tag, ".nxdERR"}, 32'(nxdERR), 32'(e));
        check({tag, ".nxdADDR"}, 32'(nxdADDR), 32'(a));
    endtask

    // Raises iolatch after at least one low cycle; WAIT is entered on the edge.
    task automatic apply_stimulus(input logic [21:0] addr);
        iolatch = 1'b0;
        step();
        iolatch = 1'b1;
        ioADDR  = addr;
        step();
        iolatch = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clken = 1'b0; iolatch = 1'b0; ioADDR = '0; ioACK = 1'b0; clrNXD = 1'b0;
        step();
        step();
        check_outputs("reset", 0, 0, 0, 0, 22'h0);
        rst = 1'b0;
        clken = 1'b1;
        step();

        // Ack while idle is ignored.
        ioACK = 1'b1;
        step();
        check_outputs("idle_ack", 0, 0, 0, 0, 22'h0);
        ioACK = 1'b0;

        // Ack five cycles after WAIT entry; a second iolatch rise in WAIT is ignored.
        apply_stimulus(22'h012345);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (ioWAIT !== 1'b1 || ioDONE !== 1'b0) bad++;
            iolatch = (k == 1);
            step();
        end
        check("ack5.wait_cycles", 32'(bad), 32'd0);
        check("ack5.wait_still", 32'(ioWAIT), 32'd1);
        ioACK = 1'b1;
        step();
        check_outputs("ack5.done", 0, 1, 0, 0, 22'h0);
        ioACK = 1'b0;
        step();
        check_outputs("ack5.idle", 0, 0, 0, 0, 22'h0);
        step();
        check("ack5.no_rearm", 32'(ioWAIT), 32'd0);

        // Full timeout at 0x3FF000.
        apply_stimulus(22'h3FF000);
        bad = 0;
        for (int k = 0; k < 63; k++) begin
            if (ioWAIT !== 1'b1 || nxdINTR !== 1'b0) bad++;
            step();
        end
        check("tmo.wait_cycles", 32'(bad), 32'd0);
        check_outputs("tmo.last_wait", 1, 0, 0, 0, 22'h0);
        step();
        check_outputs("tmo.intr", 0, 0, 1, 1, 22'h3FF000);
        step();
        check_outputs("tmo.after", 0, 0, 0, 1, 22'h3FF000);
        clrNXD = 1'b1;
        step();
        clrNXD = 1'b0;
        check_outputs("tmo.clr", 0, 0, 0, 0, 22'h3FF000);

        // Ack on the count==0 cycle wins over the timeout.
        apply_stimulus(22'h000111);
        for (int k = 0; k < 63; k++) step();
        check("race.wait", 32'(ioWAIT), 32'd1);
        ioACK = 1'b1;
        step();
        ioACK = 1'b0;
        check_outputs("race.done", 0, 1, 0, 0, 22'h3FF000);
        step();
        check_outputs("race.idle", 0, 0, 0, 0, 22'h3FF000);

        // Alternating clken: 64 enabled cycles to timeout, frozen when disabled.
        apply_stimulus(22'h155555);
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            clken = 1'b0;
            step();
            if (ioWAIT !== 1'b1 || nxdINTR !== 1'b0) bad++;
            clken = 1'b1;
            step();
            if (k < 63 && (ioWAIT !== 1'b1 || nxdINTR !== 1'b0)) bad++;
        end
        check("clken.frozen_wait", 32'(bad), 32'd0);
        check_outputs("clken.intr", 0, 0, 1, 1, 22'h155555);
        clken = 1'b0;
        step();
        check("clken.intr_held", 32'(nxdINTR), 32'd1);
        clken = 1'b1;
        step();
        check("clken.intr_done", 32'(nxdINTR), 32'd0);

        // Second timeout with clrNXD coincident: set wins, address updates.
        apply_stimulus(22'h2AAAAA);
        for (int k = 0; k < 63; k++) step();
        clrNXD = 1'b1;
        step();
        clrNXD = 1'b0;
        check_outputs("setwins.intr", 0, 0, 1, 1, 22'h2AAAAA);
        step();
        clrNXD = 1'b1;
        step();
        clrNXD = 1'b0;
        check_outputs("setwins.clr", 0, 0, 0, 0, 22'h2AAAAA);

        // Reset mid-WAIT with iolatch held high.
        iolatch = 1'b0;
        step();
        iolatch = 1'b1;
        ioADDR  = 22'h0ABCDE;
        step();
        step();
        check("rstmid.wait", 32'(ioWAIT), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_outputs("rstmid.async", 0, 0, 0, 0, 22'h0);
        step();
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (ioWAIT !== 1'b0 || ioDONE !== 1'b0 || nxdINTR !== 1'b0) bad++;
        end
        check("rstmid.no_start", 32'(bad), 32'd0);
        iolatch = 1'b0;
        step();
        check("rstmid.low", 32'(ioWAIT), 32'd0);
        iolatch = 1'b1;
        step();
        check("rstmid.restart", 32'(ioWAIT), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/nxd_timer.md
NXD_TIMER -- requirements
Module: nxd_timer

Interface
REQ-001 Parameter: nxdTIMEOUT, default 64, number of clken cycles to wait for acknowledge before declaring a non-existent device.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 clken  input  1  clock enable; no state changes when low.
REQ-005 iolatch  input  1  IO latch from upstream IO-latch stage; rising edge marks start of an IO cycle.
REQ-006 ioADDR  input  22  physical IO address of current cycle.
REQ-007 ioACK  input  1  bus acknowledge from addressed device.
REQ-008 clrNXD  input  1  microcode clear of sticky NXD flag.
REQ-009 ioWAIT  output  1  stall request to microsequencer while awaiting ack.
REQ-010 ioDONE  output  1  one-cycle pulse on acknowledged completion.
REQ-011 nxdINTR  output  1  one-cycle pulse on timeout.
REQ-012 nxdERR  output  1  sticky non-existent-device flag.
REQ-013 nxdADDR  output  22  address of the cycle that timed out.

Function
REQ-014 All sequential updates occur only on clk edges with clken=1; with clken=0 every register holds.
REQ-015 Edge detect: start = iolatch & ~lastIOLATCH; lastIOLATCH <= iolatch every enabled cycle, all states.
REQ-016 States: IDLE, WAIT, DONE, TMO.
REQ-017 IDLE: on start -> WAIT, count <= nxdTIMEOUT-1, curADDR <= ioADDR; otherwise stay.
REQ-018 WAIT: ioWAIT=1 (combinational from state); ioACK=1 -> DONE; else count==0 -> TMO; else count <= count-1.
REQ-019 ioACK and count==0 in same cycle: ack wins, -> DONE, no error.
REQ-020 DONE: ioDONE=1 for exactly one enabled cycle, then -> IDLE.
REQ-021 Entry to TMO: nxdERR <= 1, nxdADDR <= curADDR; TMO: nxdINTR=1 for one enabled cycle, then -> IDLE.
REQ-022 Timeout latency: with ioACK held low, TMO entered exactly nxdTIMEOUT enabled cycles after WAIT entry.
REQ-023 start while in WAIT, DONE or TMO is ignored; no re-arm, no count reload.
REQ-024 ioACK in IDLE, DONE or TMO is ignored.
REQ-025 clrNXD clears nxdERR; simultaneous set (TMO entry) and clrNXD: set wins.
REQ-026 nxdADDR changes only on TMO entry; unaffected by clrNXD.
REQ-027 Counter width = clog2(nxdTIMEOUT); no wrap: decrement never taken at count==0.

Reset
REQ-028 rst asynchronously forces: state IDLE, count 0, lastIOLATCH 0, curADDR 0, ioWAIT 0, ioDONE 0, nxdINTR 0, nxdERR 0, nxdADDR 0.
REQ-029 rst mid-WAIT aborts cycle with no ioDONE/nxdINTR; after release a start needs a fresh iolatch rising edge (iolatch high at release is not a start).

Structure
REQ-030 State encodings and default nxdTIMEOUT live in shared include nxd.vh; ioADDR width uses existing VMA include constants.
REQ-031 Single flat module, no sub-modules; counter and edge detect inline.

Verification
REQ-032 iolatch rise, ioACK high 5 cycles later -> ioWAIT high 5 cycles, ioDONE one pulse, nxdERR stays 0.
REQ-033 iolatch rise, ioADDR=0x3FF000, no ack -> nxdINTR pulse 64 cycles after WAIT entry, nxdERR=1, nxdADDR=0x3FF000, ioWAIT low after.
REQ-034 ioACK asserted exactly on count==0 cycle -> ioDONE pulse, no nxdINTR, nxdERR 0.
REQ-035 clken toggled 1/0 during WAIT -> timeout after 64 enabled cycles (~128 clocks); outputs frozen in disabled cycles.
REQ-036 nxdERR=1, clrNXD coincident with second timeout -> nxdERR stays 1, nxdADDR = second address; clrNXD alone later -> nxdERR 0.
REQ-037 rst pulsed mid-WAIT with iolatch held high -> all outputs 0, no new cycle until iolatch falls and rises again.
